// File: rtl/accel_core_pkg.sv
// Shared constants and types for the accelerator core datapath blocks.
// The memory-to-stream reader uses the AXI encodings and its FSM state type from here.
package accel_core_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         AXI_4K_BYTES   = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DRAIN
  } mm2s_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word and a total-occupancy count.
// An empty FIFO forwards a write straight into the head register, so data is visible the next cycle.
module sync_fifo #(
  parameter  int WIDTH = 65,
  parameter  int DEPTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] ram_cnt_reg;
  logic [WIDTH-1:0] dout_reg;
  logic             valid_reg;

  logic pop;
  logic head_free;
  logic ram_empty;
  logic bypass;
  logic ram_wr;
  logic ram_rd;

  assign pop       = valid_reg & rd_en;
  assign head_free = ~valid_reg | pop;
  assign ram_empty = (ram_cnt_reg == '0);
  assign bypass    = wr_en & ram_empty & head_free;
  assign ram_wr    = wr_en & ~bypass;
  assign ram_rd    = head_free & ~ram_empty;

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      ram_cnt_reg <= '0;
      dout_reg    <= '0;
      valid_reg   <= 1'b0;
    end else begin
      if (ram_wr) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (ram_rd) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      ram_cnt_reg <= ram_cnt_reg + CNT_W'(ram_wr) - CNT_W'(ram_rd);
      // Older array entries always take priority over the bypass path to keep order.
      if (ram_rd) begin
        dout_reg  <= mem[rd_ptr_reg];
        valid_reg <= 1'b1;
      end else if (bypass) begin
        dout_reg  <= din;
        valid_reg <= 1'b1;
      end else if (pop) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign dout  = dout_reg;
  assign valid = valid_reg;
  assign count = ram_cnt_reg + CNT_W'(valid_reg);

endmodule

// File: rtl/preproc_mm2s.sv
// Memory-to-stream reader: splits a job into AXI4 INCR bursts that never cross 4 KiB,
// reserves buffer space per burst and drains the buffer as an AXI-Stream with TLAST.
module preproc_mm2s
  import accel_core_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int LEN_W      = 24,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  num_beats,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready
);

  localparam int BYTES     = DATA_W / 8;
  localparam int SIZE_LOG2 = $clog2(BYTES);
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

  mm2s_state_t       state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  remain_reg;
  logic [LEN_W-1:0]  total_reg;
  logic [LEN_W-1:0]  out_cnt_reg;
  logic [LEN_W-1:0]  burst_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;
  logic              arvalid_reg;
  logic [ADDR_W-1:0] araddr_reg;
  logic [7:0]        arlen_reg;
  logic              rready_reg;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  fifo_space;
  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_dout;

  logic [12:0]       to_4k_bytes;
  logic [LEN_W-1:0]  to_4k_beats;
  logic [LEN_W-1:0]  burst_next;
  logic              space_ok;
  logic [LEN_W-1:0]  remain_after;
  logic [ADDR_W-1:0] addr_step;
  logic              r_fire;
  logic              s_fire;
  logic              last_fire;

  // Beats left before the address crosses the next 4 KiB page.
  assign to_4k_bytes = 13'(AXI_4K_BYTES) - {1'b0, addr_reg[11:0]};
  assign to_4k_beats = LEN_W'(to_4k_bytes >> SIZE_LOG2);

  always_comb begin
    burst_next = LEN_W'(MAX_BURST);
    if (remain_reg < burst_next) begin
      burst_next = remain_reg;
    end
    if (to_4k_beats < burst_next) begin
      burst_next = to_4k_beats;
    end
  end

  assign fifo_space   = CNT_W'(FIFO_DEPTH) - fifo_count;
  assign space_ok     = LEN_W'(fifo_space) >= burst_next;
  assign remain_after = remain_reg - burst_reg;
  assign addr_step    = ADDR_W'(burst_reg) << SIZE_LOG2;
  assign r_fire       = rvalid & rready_reg;
  assign s_fire       = m_tvalid & m_tready;
  assign last_fire    = s_fire & m_tlast;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      remain_reg  <= '0;
      total_reg   <= '0;
      out_cnt_reg <= '0;
      burst_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      arvalid_reg <= 1'b0;
      araddr_reg  <= '0;
      arlen_reg   <= '0;
      rready_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (s_fire) begin
        out_cnt_reg <= out_cnt_reg + 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            err_reg     <= 1'b0;
            out_cnt_reg <= '0;
            total_reg   <= num_beats;
            remain_reg  <= num_beats;
            addr_reg    <= base_addr;
            if (num_beats == '0) begin
              done_reg <= 1'b1;
            end else begin
              busy_reg  <= 1'b1;
              state_reg <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          // Request and length are frozen once arvalid is up, until the handshake.
          if (!arvalid_reg) begin
            if (space_ok) begin
              arvalid_reg <= 1'b1;
              araddr_reg  <= addr_reg;
              arlen_reg   <= 8'(burst_next - 1'b1);
              burst_reg   <= burst_next;
            end
          end else if (arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_fire) begin
            if (rresp != AXI_RESP_OKAY) begin
              err_reg <= 1'b1;
            end
            if (rlast) begin
              rready_reg <= 1'b0;
              remain_reg <= remain_after;
              addr_reg   <= addr_reg + addr_step;
              state_reg  <= (remain_after != '0) ? ST_ADDR : ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (last_fire) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (aclk),
    .rst_n(aresetn),
    .wr_en(r_fire),
    .din  (rdata),
    .rd_en(m_tready),
    .dout (fifo_dout),
    .valid(fifo_valid),
    .count(fifo_count)
  );

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign err      = err_reg;
  assign araddr   = araddr_reg;
  assign arlen    = arlen_reg;
  assign arsize   = 3'(SIZE_LOG2);
  assign arburst  = AXI_BURST_INCR;
  assign arvalid  = arvalid_reg;
  assign rready   = rready_reg;
  assign m_tdata  = fifo_dout;
  assign m_tvalid = fifo_valid;
  // The output beat counter only advances on handshakes, so TLAST is stable under backpressure.
  assign m_tlast  = fifo_valid & (out_cnt_reg == total_reg - 1'b1);

endmodule

// File: tb/tb_preproc_mm2s.sv
// Bench for preproc_mm2s: randomized AXI read slave and stream sink, job-level reference model.
module tb_preproc_mm2s;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 64;
  localparam int LEN_W      = 24;
  localparam int MAX_BURST  = 16;
  localparam int FIFO_DEPTH = 32;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  num_beats = '0;
  logic              busy, done, err;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready = 1'b0;
  logic [DATA_W-1:0] rdata = '0;
  logic [1:0]        rresp = '0;
  logic              rlast = 1'b0;
  logic              rvalid = 1'b0;
  logic              rready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast, m_tvalid;
  logic              m_tready = 1'b0;

  always #5 aclk = ~aclk;

  preproc_mm2s #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .base_addr(base_addr),
    .num_beats(num_beats), .busy(busy), .done(done), .err(err),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready), .m_tdata(m_tdata),
    .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Memory contents as a function of the byte address.
  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a};
  endfunction

  // Monitor / slave shared state
  int          cyc = 0;
  logic [31:0] ar_addr_q[$];
  int          ar_len_q[$];
  logic [63:0] s_data_q[$];
  bit          s_last_q[$];
  int r_total = 0, s_total = 0, max_occ = 0;
  int done_cnt = 0, done_cyc = -1, last_hs_cyc = -1;
  int bad_hs_cyc = -1, err_rise_cyc = -1, unstable = 0, arvalid_cycles = 0;
  int err_beat = -1, job_r_idx = 0, tready_mode = 0, stall_until = 0;

  initial begin : slave
    logic [31:0] pend_addr[$];
    int          pend_len[$];
    int          beat_i;
    bit          ar_hs, r_hs, hold_ar, hold_s, err_prev;
    logic [31:0] ar_a, held_araddr;
    logic [7:0]  held_arlen;
    logic [63:0] held_tdata;
    bit          held_tlast;
    int          ar_l;
    beat_i = 0; hold_ar = 0; hold_s = 0; err_prev = 0;
    forever begin
      @(negedge aclk);
      cyc++;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      ar_a  = araddr;
      ar_l  = int'(arlen);
      if (aresetn) begin
        if (arvalid) arvalid_cycles++;
        if (hold_ar && (!arvalid || araddr !== held_araddr || arlen !== held_arlen)) unstable++;
        if (hold_s && (!m_tvalid || m_tdata !== held_tdata || m_tlast !== held_tlast)) unstable++;
        hold_ar = arvalid && !arready; held_araddr = araddr; held_arlen = arlen;
        hold_s = m_tvalid && !m_tready; held_tdata = m_tdata; held_tlast = m_tlast;
        if (ar_hs) begin
          ar_addr_q.push_back(araddr);
          ar_len_q.push_back(int'(arlen));
        end
        if (r_hs) begin
          r_total++;
          if (rresp != 2'b00) bad_hs_cyc = cyc;
        end
        if (m_tvalid && m_tready) begin
          s_total++;
          s_data_q.push_back(m_tdata);
          s_last_q.push_back(m_tlast);
          if (m_tlast) last_hs_cyc = cyc;
        end
        if (r_total - s_total > max_occ) max_occ = r_total - s_total;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (err && !err_prev) err_rise_cyc = cyc;
        err_prev = err;
      end else begin
        hold_ar = 0; hold_s = 0; err_prev = 0;
      end
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        pend_addr.delete(); pend_len.delete(); beat_i = 0;
        rvalid = 0; rlast = 0; arready = 0;
      end else begin
        if (ar_hs) begin
          pend_addr.push_back(ar_a);
          pend_len.push_back(ar_l);
        end
        if (r_hs && pend_len.size() > 0) begin
          job_r_idx++;
          beat_i++;
          if (beat_i > pend_len[0]) begin
            void'(pend_addr.pop_front());
            void'(pend_len.pop_front());
            beat_i = 0;
          end
        end
        arready = ($urandom_range(0, 3) != 0);
        if (pend_len.size() > 0 && $urandom_range(0, 3) != 0) begin
          rvalid = 1;
          rdata  = pat(pend_addr[0] + 32'(beat_i * 8));
          rlast  = (beat_i == pend_len[0]);
          rresp  = (job_r_idx == err_beat) ? 2'b10 : 2'b00;
        end else begin
          rvalid = 0; rlast = 0; rresp = 2'b00;
        end
        case (tready_mode)
          0:       m_tready = 1;
          1:       m_tready = ($urandom_range(0, 2) != 0);
          default: m_tready = (cyc >= stall_until);
        endcase
      end
    end
  end

  task automatic clear_stats();
    ar_addr_q.delete(); ar_len_q.delete(); s_data_q.delete(); s_last_q.delete();
    r_total = 0; s_total = 0; max_occ = 0; unstable = 0;
    bad_hs_cyc = -1; err_rise_cyc = -1; job_r_idx = 0;
  endtask

  task automatic run_job(input logic [31:0] base, input int n, input int mode,
                         input int eb, input int exp_ars, input bit busy_start);
    logic [31:0] ea[$];
    int          el[$];
    logic [31:0] a;
    int rem, len, d0, t, na, nb;
    bit exp_err;
    // Reference: split into bursts of min(MAX_BURST, remaining, beats to 4 KiB page end)
    a = base; rem = n;
    while (rem > 0) begin
      len = MAX_BURST;
      if (rem < len) len = rem;
      if ((4096 - int'(a[11:0])) / 8 < len) len = (4096 - int'(a[11:0])) / 8;
      ea.push_back(a); el.push_back(len);
      a = a + 32'(len * 8); rem -= len;
    end
    clear_stats();
    err_beat = eb; tready_mode = mode; stall_until = cyc + 100;
    d0 = done_cnt;
    @(posedge aclk); #1;
    start = 1; base_addr = base; num_beats = 24'(n);
    @(posedge aclk); #1;
    start = 0; base_addr = $urandom; num_beats = 24'($urandom);
    chk("busy_after_start", 64'(busy), 64'(1));
    chk("err_cleared_on_start", 64'(err), 64'(0));
    if (busy_start) begin
      repeat (3) @(posedge aclk);
      #1; start = 1; base_addr = 32'h0000_8000; num_beats = 24'd5;
      @(posedge aclk); #1; start = 0;
    end
    if (mode == 2 && n >= FIFO_DEPTH + MAX_BURST) begin
      t = 0;
      while (cyc < stall_until && t < 2000) begin
        @(posedge aclk); #1; t++;
      end
      chk("stall_r_beats", 64'(r_total), 64'(FIFO_DEPTH));
      chk("stall_arvalid_low", 64'(arvalid), 64'(0));
    end
    t = 0;
    while (done_cnt == d0 && t < 5000) begin
      @(posedge aclk); #1; t++;
    end
    repeat (4) @(posedge aclk);
    #1;
    chk("done_pulses", 64'(done_cnt - d0), 64'(1));
    chk("done_after_last", 64'(done_cyc), 64'(last_hs_cyc + 1));
    chk("busy_end", 64'(busy), 64'(0));
    chk("ar_count", 64'(ar_addr_q.size()), 64'(ea.size()));
    if (exp_ars >= 0) chk("ar_count_table", 64'(ar_addr_q.size()), 64'(exp_ars));
    na = (ar_addr_q.size() < ea.size()) ? ar_addr_q.size() : ea.size();
    for (int i = 0; i < na; i++) begin
      chk("araddr", 64'(ar_addr_q[i]), 64'(ea[i]));
      chk("arlen", 64'(ar_len_q[i]), 64'(el[i] - 1));
    end
    chk("beat_count", 64'(s_data_q.size()), 64'(n));
    nb = (s_data_q.size() < n) ? s_data_q.size() : n;
    for (int i = 0; i < nb; i++) begin
      chk("tdata", s_data_q[i], pat(base + 32'(i * 8)));
      chk("tlast", 64'(s_last_q[i]), 64'(i == n - 1));
    end
    exp_err = (eb >= 0 && eb < n);
    chk("err_sticky", 64'(err), 64'(exp_err));
    if (exp_err) chk("err_rise_timing", 64'(err_rise_cyc), 64'(bad_hs_cyc + 1));
    chk("occupancy_bound", 64'(max_occ <= FIFO_DEPTH), 64'(1));
    chk("handshake_stable", 64'(unstable), 64'(0));
    $display("job base=0x%08h beats=%0d ars=%0d streamed=%0d err=%0d max_occ=%0d",
             base, n, ar_addr_q.size(), s_data_q.size(), err, max_occ);
  endtask

  typedef struct {
    logic [31:0] base;
    int          n;
    int          mode;
    int          eb;
    int          exp_ars;
    bit          busy_start;
  } vec_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl[9];
    int   d0, a0, t;
    tbl[0] = '{32'h0000_1000, 40, 0, -1, 3, 1'b0};
    tbl[1] = '{32'h0000_0FC0, 20, 1, -1, 2, 1'b0};
    tbl[2] = '{32'h0000_2000, 64, 2, -1, 4, 1'b0};
    tbl[3] = '{32'h0000_3000, 16, 1,  4, 1, 1'b0};
    tbl[4] = '{32'h0000_4000, 24, 1, -1, 2, 1'b1};
    for (int i = 5; i < 9; i++) begin
      tbl[i].base = 32'h0001_0000 + {19'd0, 10'($urandom_range(0, 1023)), 3'b000};
      tbl[i].n = $urandom_range(1, 100);
      tbl[i].mode = 1;
      tbl[i].eb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, tbl[i].n - 1) : -1;
      tbl[i].exp_ars = -1;
      tbl[i].busy_start = 1'b0;
    end

    repeat (3) @(posedge aclk);
    #1;
    chk("reset_outputs", {busy, done, err, arvalid, rready, m_tvalid}, 64'(0));
    chk("reset_ar", {araddr, 24'd0, arlen}, 64'(0));
    chk("reset_tdata", m_tdata, 64'(0));
    chk("arsize_const", 64'(arsize), 64'(3));
    chk("arburst_const", 64'(arburst), 64'(1));
    aresetn = 1;
    repeat (2) @(posedge aclk);
    #1;

    for (int i = 0; i < 9; i++) begin
      run_job(tbl[i].base, tbl[i].n, tbl[i].mode, tbl[i].eb, tbl[i].exp_ars, tbl[i].busy_start);
    end

    // Zero-length job: done one cycle after start, no AR, busy never set.
    d0 = done_cnt; a0 = arvalid_cycles;
    @(posedge aclk); #1;
    start = 1; base_addr = 32'h0000_7000; num_beats = '0;
    @(posedge aclk); #1;
    start = 0;
    chk("zero_done", 64'(done), 64'(1));
    chk("zero_busy", 64'(busy), 64'(0));
    @(posedge aclk); #1;
    chk("zero_done_one_cycle", 64'(done), 64'(0));
    repeat (6) @(posedge aclk);
    #1;
    chk("zero_no_arvalid", 64'(arvalid_cycles - a0), 64'(0));
    chk("zero_done_count", 64'(done_cnt - d0), 64'(1));
    $display("job base=0x00007000 beats=0 done_pulses=%0d", done_cnt - d0);

    // Reset in the middle of the data phase.
    clear_stats();
    err_beat = -1; tready_mode = 0;
    @(posedge aclk); #1;
    start = 1; base_addr = 32'h0000_5000; num_beats = 24'd64;
    @(posedge aclk); #1;
    start = 0;
    t = 0;
    while (!(r_total >= 3 && rready) && t < 500) begin
      @(posedge aclk); #1; t++;
    end
    chk("reached_data_phase", 64'(rready), 64'(1));
    #2;
    aresetn = 0;
    #1;
    chk("midjob_reset_ctrl", {busy, done, err, arvalid, rready, m_tvalid}, 64'(0));
    chk("midjob_reset_ar", {araddr, 24'd0, arlen}, 64'(0));
    chk("midjob_reset_tdata", m_tdata, 64'(0));
    repeat (3) @(posedge aclk);
    #3;
    aresetn = 1;
    $display("job base=0x00005000 beats=64 aborted by reset after %0d R beats", r_total);
    repeat (2) @(posedge aclk);
    #1;
    run_job(32'h0000_6000, 8, 1, -1, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
